cim_lookup_engine: RTL

Parametrised continuous-item-memory (CIM) lookup engine, successor to the fixed six-channel CIM wrapper. It accepts (channel, feature-level) requests over a valid/ready handshake and translates each one through a runtime-programmable per-channel base/count table into an item-memory address. It drives an external read port of configurable latency and returns the hypervector in request order through an output FIFO with backpressure. It sits between the feature sequencer and the spatial/temporal encoders.

---
 rtl/cim_lookup_engine.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/cim_lookup_engine.sv
// ----------------------------------------------------------------------------
// cim_lookup_engine
//
// Continuous-item-memory lookup engine. Each accepted (channel, feature level)
// request is translated through a runtime-programmable per-channel
// {base, count} table into an item-memory address. The engine drives an
// external read port of MEM_LATENCY cycles latency, then returns the
// hypervector through an output FIFO, strictly in acceptance order. Requests
// that fall outside a channel's range, or that name a nonexistent channel,
// still occupy a slot so that ordering is kept. Their result is flagged
// with out_err and carries an all-zero hypervector.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   i_cfg_we          table write strobe
//   i_cfg_chan        table entry to write
//   i_cfg_base        base address for that entry
//   i_cfg_count       number of valid feature levels (0 = channel disabled)
//   i_req_valid       request valid
//   o_req_ready       request ready (decoded from the occupancy register only)
//   i_req_chan        request channel
//   i_req_feature     request feature level
//   o_mem_en          item-memory read strobe
//   o_mem_addr        item-memory read address
//   i_mem_dout        item-memory read data, MEM_LATENCY cycles after o_mem_en
//   o_out_valid       result valid (output FIFO not empty)
//   i_out_ready       result ready
//   o_out_hv          looked-up hypervector (0 when empty or on error)
//   o_out_chan        channel of the result
//   o_out_err         result is a range or channel violation
//   o_busy            requests accepted but not yet popped
// ----------------------------------------------------------------------------
module cim_lookup_engine #(
    parameter int HV_DIM        = 2000,
    parameter int NUM_CHANNELS  = 6,
    parameter int CHAN_WIDTH    = 3,
    parameter int FEATURE_WIDTH = 8,
    parameter int ADDR_WIDTH    = 12,
    parameter int MEM_LATENCY   = 1,
    parameter int OUT_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cfg_we,
    input  logic [CHAN_WIDTH-1:0]    i_cfg_chan,
    input  logic [ADDR_WIDTH-1:0]    i_cfg_base,
    input  logic [FEATURE_WIDTH:0]   i_cfg_count,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [CHAN_WIDTH-1:0]    i_req_chan,
    input  logic [FEATURE_WIDTH-1:0] i_req_feature,
    output logic                     o_mem_en,
    output logic [ADDR_WIDTH-1:0]    o_mem_addr,
    input  logic [HV_DIM-1:0]        i_mem_dout,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [HV_DIM-1:0]        o_out_hv,
    output logic [CHAN_WIDTH-1:0]    o_out_chan,
    output logic                     o_out_err,
    output logic                     o_busy
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCC_W = $clog2(OUT_DEPTH + 1);

    // Channel table
    logic [ADDR_WIDTH-1:0]    r_base  [NUM_CHANNELS];
    logic [FEATURE_WIDTH:0]   r_count [NUM_CHANNELS];

    // Request lookup
    logic [ADDR_WIDTH-1:0]    w_selBase;
    logic [FEATURE_WIDTH:0]   w_selCount;
    logic                     w_chanOk;
    logic [ADDR_WIDTH-1:0]    w_addr;
    logic                     w_err;
    logic                     w_accept;
    logic                     w_pop;

    // Slot arriving at the FIFO write port, aligned with i_mem_dout
    logic                     w_wrValid;
    logic [CHAN_WIDTH-1:0]    w_wrChan;
    logic                     w_wrErr;

    // Output FIFO
    logic [HV_DIM-1:0]        r_fifoHv   [OUT_DEPTH];
    logic [CHAN_WIDTH-1:0]    r_fifoChan [OUT_DEPTH];
    logic                     r_fifoErr  [OUT_DEPTH];
    logic [PTR_W-1:0]         r_wrPtr;
    logic [PTR_W-1:0]         r_rdPtr;
    logic [OCC_W-1:0]         r_fifoCnt;
    logic [OCC_W-1:0]         r_occ;
    logic                     w_notEmpty;

    function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] p);
        return (32'(p) == OUT_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // Writes to a channel index beyond NUM_CHANNELS match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_base[i]  <= '0;
                r_count[i] <= '0;
            end
        end else if (i_cfg_we) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (32'(i_cfg_chan) == i) begin
                    r_base[i]  <= i_cfg_base;
                    r_count[i] <= i_cfg_count;
                end
            end
        end
    end

    // A same-cycle table write is not yet visible here, so a colliding request
    // sees the old entry.
    always_comb begin
        w_selBase  = '0;
        w_selCount = '0;
        w_chanOk   = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (32'(i_req_chan) == i) begin
                w_selBase  = r_base[i];
                w_selCount = r_count[i];
                w_chanOk   = 1'b1;
            end
        end
    end

    // The address wraps modulo 2^ADDR_WIDTH.
    assign w_addr      = w_selBase + ADDR_WIDTH'(i_req_feature);
    assign w_err       = !w_chanOk || ({1'b0, i_req_feature} >= w_selCount);
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_pop       = o_out_valid & i_out_ready;

    assign o_mem_en    = w_accept & ~w_err;
    assign o_mem_addr  = o_mem_en ? w_addr : '0;

    // The slot pipe runs freely. Occupancy accounting guarantees that every slot
    // leaving it finds room in the FIFO.
    generate
        if (MEM_LATENCY == 0) begin : g_noPipe
            assign w_wrValid = w_accept;
            assign w_wrChan  = i_req_chan;
            assign w_wrErr   = w_err;
        end else begin : g_pipe
            logic                  r_pipeValid [MEM_LATENCY];
            logic [CHAN_WIDTH-1:0] r_pipeChan  [MEM_LATENCY];
            logic                  r_pipeErr   [MEM_LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < MEM_LATENCY; s++) begin
                        r_pipeValid[s] <= 1'b0;
                        r_pipeChan[s]  <= '0;
                        r_pipeErr[s]   <= 1'b0;
                    end
                end else begin
                    r_pipeValid[0] <= w_accept;
                    r_pipeChan[0]  <= i_req_chan;
                    r_pipeErr[0]   <= w_err;
                    for (int s = 1; s < MEM_LATENCY; s++) begin
                        r_pipeValid[s] <= r_pipeValid[s-1];
                        r_pipeChan[s]  <= r_pipeChan[s-1];
                        r_pipeErr[s]   <= r_pipeErr[s-1];
                    end
                end
            end

            assign w_wrValid = r_pipeValid[MEM_LATENCY-1];
            assign w_wrChan  = r_pipeChan[MEM_LATENCY-1];
            assign w_wrErr   = r_pipeErr[MEM_LATENCY-1];
        end
    endgenerate

    // The FIFO storage needs no reset. The head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_wrValid) begin
            r_fifoHv[r_wrPtr]   <= w_wrErr ? '0 : i_mem_dout;
            r_fifoChan[r_wrPtr] <= w_wrChan;
            r_fifoErr[r_wrPtr]  <= w_wrErr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fifoCnt <= '0;
        end else begin
            if (w_wrValid) begin
                r_wrPtr <= ptrNext(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= ptrNext(r_rdPtr);
            end
            case ({w_wrValid, w_pop})
                2'b10:   r_fifoCnt <= r_fifoCnt + OCC_W'(1);
                2'b01:   r_fifoCnt <= r_fifoCnt - OCC_W'(1);
                default: r_fifoCnt <= r_fifoCnt;
            endcase
        end
    end

    // Occupancy covers slots in the pipe as well as in the FIFO. It is what
    // throttles acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_req_ready = (32'(r_occ) < OUT_DEPTH);
    assign o_busy      = (r_occ != '0);
    assign w_notEmpty  = (r_fifoCnt != '0);
    assign o_out_valid = w_notEmpty;
    assign o_out_hv    = w_notEmpty ? r_fifoHv[r_rdPtr]   : '0;
    assign o_out_chan  = w_notEmpty ? r_fifoChan[r_rdPtr] : '0;
    assign o_out_err   = w_notEmpty ? r_fifoErr[r_rdPtr]  : 1'b0;

endmodule
